// File: rtl/snake_pkg.sv
// snake_pkg: shared coordinate/grid types and the seeded initial body.
// INIT_LEN is shared with the snake length counter so both agree on the starting length.
package snake_pkg;

    localparam int GRID_DIM = 16;
    localparam int COORD_W  = 4;
    localparam int INIT_LEN = 3;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

    typedef logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_t;

    // Initial body, tail first: (5,8) -> (6,8) -> (7,8) with the head at (7,8).
    localparam coord_t INIT_SEG0 = '{x: 4'd5, y: 4'd8};
    localparam coord_t INIT_SEG1 = '{x: 4'd6, y: 4'd8};
    localparam coord_t INIT_SEG2 = '{x: 4'd7, y: 4'd8};

    // Bitmap with a single cell set, indexed [y][x].
    function automatic grid_t cell_onehot(input coord_t c);
        grid_t g;
        g = '0;
        g[c.y][c.x] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/snake_body_chk.sv
// snake_body_chk: simulation-only checks on the inputs of snake_body.
module snake_body_chk
    import snake_pkg::*;
(
    input logic       clk,
    input logic       reset,
    input logic       slow_edge,
    input logic [7:0] snake_length
);

    // A tick with a body shorter than the seeded length is illegal upstream behaviour.
    a_min_len: assert property (@(posedge clk) disable iff (reset)
        slow_edge |-> (snake_length >= 8'(INIT_LEN)));

endmodule

// File: rtl/snake_ring_buf.sv
// snake_ring_buf: circular store of body segments. The head pointer lives here;
// pushing writes the new head one slot ahead, and the tail is read combinationally
// L-1 slots behind the head.
module snake_ring_buf
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  coord_t     wr_data,
    input  logic [8:0] len,
    output coord_t     tail_data
);

    localparam int PTR_W = $clog2(MAX_LEN);

    coord_t           mem_r [MAX_LEN];
    logic [PTR_W-1:0] head_ptr_r;
    logic [PTR_W-1:0] tail_idx_s;
    logic [8:0]       len_m1_s;

    // Tail index: L-1 entries behind the head, wrapping modulo the ring depth.
    always_comb begin
        len_m1_s   = len - 9'd1;
        tail_idx_s = head_ptr_r - len_m1_s[PTR_W-1:0];
    end

    assign tail_data = mem_r[tail_idx_s];

    // Seed the initial body on reset, otherwise append the new head when pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r[0]   <= INIT_SEG0;
            mem_r[1]   <= INIT_SEG1;
            mem_r[2]   <= INIT_SEG2;
            head_ptr_r <= PTR_W'(INIT_LEN - 1);
        end else if (push) begin
            mem_r[head_ptr_r + PTR_W'(1)] <= wr_data;
            head_ptr_r                    <= head_ptr_r + PTR_W'(1);
        end
    end

endmodule

// File: rtl/snake_body.sv
// snake_body: segment ring buffer plus 16x16 occupancy bitmap with self-collision
// detection. Optional macro SNAKE_BODY_HEAD_GRID_EN adds a one-hot head_grid output
// so the display can colour the head differently.
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int GRID    = GRID_DIM
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      slow_edge,
    input  logic                      grow,
    input  logic [7:0]                snake_length,
    input  logic [COORD_W-1:0]        head_x,
    input  logic [COORD_W-1:0]        head_y,
    output logic [GRID-1:0][GRID-1:0] grid,
    output logic                      self_hit,
    output logic                      dead,
    output logic                      full
`ifdef SNAKE_BODY_HEAD_GRID_EN
    ,
    output logic [GRID-1:0][GRID-1:0] head_grid
`endif
);

    localparam grid_t INIT_GRID = cell_onehot(INIT_SEG0) | cell_onehot(INIT_SEG1)
                                | cell_onehot(INIT_SEG2);

    logic [8:0]                len_s;
    logic                      at_max_s;
    logic                      eff_grow_s;
    logic                      tick_s;
    logic                      hit_s;
    logic                      push_s;
    coord_t                    new_head_s;
    coord_t                    tail_s;
    logic [GRID-1:0][GRID-1:0] grid_r;
    logic [GRID-1:0][GRID-1:0] grid_nxt_s;
    logic                      self_hit_r;
    logic                      dead_r;
    logic                      full_r;

    snake_ring_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .wr_data   (new_head_s),
        .len       (len_s),
        .tail_data (tail_s)
    );

    snake_body_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .slow_edge    (slow_edge),
        .snake_length (snake_length)
    );

    // Clamp length to the ring depth and decide whether this tick is a collision.
    always_comb begin
        if ({1'b0, snake_length} >= 9'(MAX_LEN)) begin
            len_s = 9'(MAX_LEN);
        end else begin
            len_s = {1'b0, snake_length};
        end
        at_max_s   = (len_s == 9'(MAX_LEN));
        eff_grow_s = grow & ~at_max_s;
        new_head_s = '{x: head_x, y: head_y};
        tick_s     = slow_edge & ~dead_r;
        // Landing on the tail that is about to vacate is legal; growing into it is not.
        hit_s      = grid_r[head_y][head_x] & ~(~eff_grow_s & (tail_s == new_head_s));
        push_s     = tick_s & ~hit_s;
    end

    // Next occupancy: vacate the tail unless growing, then mark the new head (set wins).
    always_comb begin
        grid_nxt_s = grid_r;
        if (push_s) begin
            if (!eff_grow_s) begin
                grid_nxt_s[tail_s.y][tail_s.x] = 1'b0;
            end else begin
                grid_nxt_s[tail_s.y][tail_s.x] = grid_r[tail_s.y][tail_s.x];
            end
            grid_nxt_s[head_y][head_x] = 1'b1;
        end else begin
            grid_nxt_s = grid_r;
        end
    end

    // Bitmap, collision pulse and sticky flags; reset overrides any tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            grid_r     <= INIT_GRID;
            self_hit_r <= 1'b0;
            dead_r     <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            grid_r     <= grid_nxt_s;
            self_hit_r <= tick_s & hit_s;
            if (tick_s & hit_s) begin
                dead_r <= 1'b1;
            end
            if (tick_s & grow & at_max_s) begin
                full_r <= 1'b1;
            end
        end
    end

    assign grid     = grid_r;
    assign self_hit = self_hit_r;
    assign dead     = dead_r;
    assign full     = full_r;

`ifdef SNAKE_BODY_HEAD_GRID_EN
    logic [GRID-1:0][GRID-1:0] head_grid_r;

    // One-hot head marker, moving only when the body actually advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_grid_r <= cell_onehot(INIT_SEG2);
        end else if (push_s) begin
            head_grid_r <= cell_onehot(new_head_s);
        end
    end

    assign head_grid = head_grid_r;
`endif

endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Downstream consumer of the snake length counter. Holds the snake's segment coordinates in a circular buffer and keeps a 16x16 occupancy bitmap for the LED-matrix driver.
- Detects self-collision.
- On each game tick it pushes the new head, then vacates the tail unless growing. It uses the same `grow` pulse and `snake_length` value that the length counter uses.

Parameters:
- MAX_LEN, 64, depth of the segment ring buffer; must be a power of 2, at most 256.
- GRID, 16, matrix edge length; coordinates are $clog2(GRID) bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- slow_edge  input  1  one-cycle game-tick strobe
- grow  input  1  food eaten this tick; same signal as the length counter's inc
- snake_length  input  8  current length from the length counter (pre-increment value on the tick cycle)
- head_x  input  4  x of the next head cell, valid when slow_edge=1
- head_y  input  4  y of the next head cell, valid when slow_edge=1
- grid  output  [GRID-1:0][GRID-1:0]  occupancy bitmap, indexed grid[y][x]
- self_hit  output  1  one-cycle pulse when the new head lands on the body
- dead  output  1  sticky; the body is frozen
- full  output  1  sticky; length reached MAX_LEN and growth was ignored

Behaviour:
- Reset (sync, clk edge with reset=1):
  - buf[0..2] = (5,8),(6,8),(7,8); head_ptr=2.
  - grid has exactly those 3 cells set.
  - self_hit=0, dead=0, full=0.
  - This matches the length counter's reset length of 3.
- Segment k (k=0 is the head) is buf[(head_ptr-k) mod MAX_LEN], for k < L.
  - L = min(snake_length, MAX_LEN).
  - Unused entries are don't-care.
- Tick: a clk edge with slow_edge=1, dead=0, reset=0.
  - tail_idx = (head_ptr-(L-1)) mod MAX_LEN.
  - eff_grow = grow && (L < MAX_LEN).
  - If grow && L >= MAX_LEN, set full and treat the tick as non-grow.
  - hit = grid[head_y][head_x] && !( !eff_grow && buf[tail_idx]==(head_x,head_y) ).
  - Moving into the vacating tail cell is legal. Growing into the tail is a hit.
  - If hit: self_hit=1 for exactly one cycle, dead=1, and buf/grid/head_ptr are unchanged.
  - Otherwise:
    - head_ptr <= head_ptr+1; buf[head_ptr+1] <= (head_x,head_y).
    - If !eff_grow, clear grid at buf[tail_idx].
    - Set grid at the new head. When clear and set hit the same cell, set wins.
- Latency:
  - grid reflects the tick on the cycle after the slow_edge edge.
  - self_hit is registered and asserts in that same cycle.
- No tick (slow_edge=0): all state holds, and self_hit=0.
- dead=1: ticks are ignored and state is frozen until reset. Only reset clears dead and full.
- Reset mid-tick: reset has priority over slow_edge.
- Coordinate wrap at the grid edge is the upstream head generator's job. Inputs are always in range.
- head_ptr wraps modulo MAX_LEN. No pointer overflow state exists.
- snake_length < 3 is illegal input. Behaviour is unspecified and is covered by an assertion in simulation.

Optional Feature:
- Macro: SNAKE_BODY_HEAD_GRID_EN.
- Defined:
  - Adds output head_grid [GRID-1:0][GRID-1:0], one-hot at the current head cell.
  - Reset one-hot is (7,8).
  - Updates with the same latency as grid and freezes when dead.
  - Lets the display use a distinct head colour.
- Undefined: the port and its logic are absent; other behaviour is identical.

Decomposition:
- Package snake_pkg holds:
  - GRID_DIM=16 and COORD_W=4
  - typedef coord_t, a packed struct {x, y}
  - typedef grid_t
  - INIT_LEN=3 and the init coordinate constants
- The length counter also uses INIT_LEN.
- One sub-module, snake_ring_buf:
  - MAX_LEN x coord_t storage
  - write port at head_ptr+1
  - combinational read port at tail_idx
  - owns head_ptr
- snake_body keeps grid, the hit logic and the flags.

Test Plan:
- Reset: assert reset for 1 cycle. grid has only (5,8),(6,8),(7,8) set; self_hit=0, dead=0, full=0.
- Plain move: tick with head=(8,8), grow=0, L=3. Next cycle (5,8) is cleared and (8,8) is set; the popcount stays 3.
- Grow: tick with head=(8,8), grow=1, L=3. Then tick with head=(9,8), grow=0, L=4. After that, cells (5..9,8) minus (5,8) are set; the popcount is 4.
- Tail chase: build an L=4 square loop and move the head into the vacating tail cell with grow=0. self_hit stays 0 and the cell stays set. Repeat with grow=1: self_hit pulses 1 cycle, dead=1, and grid is unchanged.
- Frozen: after dead, apply 5 ticks with new heads. grid is unchanged. Then reset restores the initial 3 cells and dead=0.
- Full: drive L=64 with grow=1 on a tick. full=1, the tail is cleared, and the popcount stays 64. With SNAKE_BODY_HEAD_GRID_EN, head_grid is one-hot at the latest head after every tick.
